// File: rtl/vscpu_ws.sv
// vscpu_ws: multi-cycle accumulator-memory CPU for the VerySimple ISA.
// Every memory access is a registered req/ready handshake, so wait states are tolerated.
module vscpu_ws #(
  parameter int unsigned ADDR_W   = 14,
  parameter int unsigned DATA_W   = 32,
  parameter int unsigned RESET_PC = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_ready,
  input  logic              halt_req,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              halted,
  output logic              retired,
  output logic [ADDR_W-1:0] pc
);

  localparam logic [3:0] OP_CP    = 4'd8;
  localparam logic [3:0] OP_CPIMM = 4'd9;
  localparam logic [3:0] OP_CPIND = 4'd10;
  localparam logic [3:0] OP_CPIST = 4'd11;
  localparam logic [3:0] OP_BZJ   = 4'd12;
  localparam logic [3:0] OP_BZJI  = 4'd13;

  localparam logic [DATA_W-1:0] DW = DATA_W'(DATA_W);

  typedef enum logic [2:0] {
    S_BOOT,
    S_FETCH,
    S_RD_A,
    S_RD_B,
    S_RD_IND,
    S_WRITE,
    S_HALT
  } state_t;

  state_t            st_q, st_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] iw_q, iw_d;
  logic [DATA_W-1:0] r1_q, r1_d;
  logic [DATA_W-1:0] r2_q, r2_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic              req_q, req_d;
  logic              we_q, we_d;
  logic              ret_q, ret_d;
  logic              hlt_q, hlt_d;

  logic [DATA_W-1:0] cur_iw;
  logic [3:0]        op;
  logic [ADDR_W-1:0] fa;
  logic [ADDR_W-1:0] fb;
  logic [DATA_W-1:0] imm;
  logic              is_alu;
  logic              done;

  logic              go;
  logic              bnd;
  state_t            nx_st;
  logic [ADDR_W-1:0] nx_addr;
  logic [ADDR_W-1:0] bnd_pc;
  logic [DATA_W-1:0] nx_wd;

  // During FETCH the instruction is decoded straight off the bus.
  assign cur_iw = (st_q == S_FETCH) ? mem_rdata : iw_q;
  assign op     = cur_iw[DATA_W-1 -: 4];
  assign fa     = cur_iw[2*ADDR_W-1:ADDR_W];
  assign fb     = cur_iw[ADDR_W-1:0];
  assign imm    = DATA_W'(fb);
  assign is_alu = !op[3] || (op[3:1] == 3'b111);
  assign done   = req_q && mem_ready;

  function automatic logic [DATA_W-1:0] alu(
    input logic [2:0]        f,
    input logic [DATA_W-1:0] a,
    input logic [DATA_W-1:0] b
  );
    logic [DATA_W-1:0] r;
    r = '0;
    case (f)
      3'd0:    r = a + b;
      3'd1:    r = ~(a & b);
      3'd2:    r = (b < DW) ? (a >> b) : (a << (b - DW));
      3'd3:    r = DATA_W'(a < b);
      3'd7:    r = a * b;
      default: r = '0;
    endcase
    return r;
  endfunction

  always_comb begin
    st_d    = st_q;
    pc_d    = pc_q;
    iw_d    = iw_q;
    r1_d    = r1_q;
    r2_d    = r2_q;
    req_d   = req_q;
    we_d    = we_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    ret_d   = 1'b0;
    hlt_d   = hlt_q;
    go      = 1'b0;
    bnd     = 1'b0;
    nx_st   = S_FETCH;
    nx_addr = fa;
    nx_wd   = '0;
    bnd_pc  = pc_q + 1'b1;

    unique case (st_q)
      S_BOOT: begin
        bnd    = 1'b1;
        bnd_pc = pc_q;
      end
      S_FETCH: if (done) begin
        iw_d = mem_rdata;
        go   = 1'b1;
        unique case (1'b1)
          op == OP_CPIMM: begin
            nx_st = S_WRITE;
            nx_wd = imm;
          end
          (op == OP_CP) || (op == OP_CPIND) || (op == OP_BZJ): begin
            nx_st   = S_RD_B;
            nx_addr = fb;
          end
          default: nx_st = S_RD_A;
        endcase
      end
      S_RD_A: if (done) begin
        r1_d = mem_rdata;
        unique case (1'b1)
          op == OP_BZJ: begin
            bnd    = 1'b1;
            bnd_pc = (r2_q == '0) ? mem_rdata[ADDR_W-1:0] : pc_q + 1'b1;
          end
          op == OP_BZJI: begin
            bnd    = 1'b1;
            bnd_pc = mem_rdata[ADDR_W-1:0] + fb;
          end
          is_alu && op[0]: begin
            go    = 1'b1;
            nx_st = S_WRITE;
            nx_wd = alu(op[3:1], mem_rdata, imm);
          end
          default: begin
            go      = 1'b1;
            nx_st   = S_RD_B;
            nx_addr = fb;
          end
        endcase
      end
      S_RD_B: if (done) begin
        r2_d = mem_rdata;
        go   = 1'b1;
        unique case (1'b1)
          op == OP_BZJ: nx_st = S_RD_A;
          op == OP_CPIND: begin
            nx_st   = S_RD_IND;
            nx_addr = mem_rdata[ADDR_W-1:0];
          end
          op == OP_CPIST: begin
            nx_st   = S_WRITE;
            nx_addr = r1_q[ADDR_W-1:0];
            nx_wd   = mem_rdata;
          end
          op == OP_CP: begin
            nx_st = S_WRITE;
            nx_wd = mem_rdata;
          end
          default: begin
            nx_st = S_WRITE;
            nx_wd = alu(op[3:1], r1_q, mem_rdata);
          end
        endcase
      end
      S_RD_IND: if (done) begin
        go    = 1'b1;
        nx_st = S_WRITE;
        nx_wd = mem_rdata;
      end
      S_WRITE: if (done) begin
        bnd = 1'b1;
      end
      S_HALT: begin
        if (!halt_req) begin
          go      = 1'b1;
          nx_st   = S_FETCH;
          nx_addr = pc_q;
          hlt_d   = 1'b0;
        end else begin
          hlt_d = 1'b1;
        end
      end
      default: ;
    endcase

    if (bnd) begin
      pc_d  = bnd_pc;
      ret_d = (st_q != S_BOOT);
      if (halt_req) begin
        st_d    = S_HALT;
        req_d   = 1'b0;
        we_d    = 1'b0;
        addr_d  = '0;
        wdata_d = '0;
        // the retire cycle reports retired; halted follows one cycle later
        hlt_d   = (st_q == S_BOOT);
      end else begin
        go      = 1'b1;
        nx_st   = S_FETCH;
        nx_addr = bnd_pc;
      end
    end

    if (go) begin
      st_d    = nx_st;
      req_d   = 1'b1;
      we_d    = (nx_st == S_WRITE);
      addr_d  = nx_addr;
      wdata_d = (nx_st == S_WRITE) ? nx_wd : '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      st_q    <= S_BOOT;
      pc_q    <= ADDR_W'(RESET_PC);
      addr_q  <= '0;
      iw_q    <= '0;
      r1_q    <= '0;
      r2_q    <= '0;
      wdata_q <= '0;
      req_q   <= 1'b0;
      we_q    <= 1'b0;
      ret_q   <= 1'b0;
      hlt_q   <= 1'b0;
    end else begin
      st_q    <= st_d;
      pc_q    <= pc_d;
      addr_q  <= addr_d;
      iw_q    <= iw_d;
      r1_q    <= r1_d;
      r2_q    <= r2_d;
      wdata_q <= wdata_d;
      req_q   <= req_d;
      we_q    <= we_d;
      ret_q   <= ret_d;
      hlt_q   <= hlt_d;
    end
  end

  assign mem_req   = req_q;
  assign mem_we    = we_q;
  assign mem_addr  = addr_q;
  assign mem_wdata = wdata_q;
  assign halted    = hlt_q;
  assign retired   = ret_q;
  assign pc        = pc_q;

endmodule

// File: tb/tb_vscpu_ws.sv
// tb_vscpu_ws: directed programs for vscpu_ws against a wait-state RAM model.
// Expected writes and retires are queued by the stimulus and popped by a monitor.
module tb_vscpu_ws;

  localparam int AW = 14;
  localparam int DW = 32;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [DW-1:0] mem_rdata;
  logic          mem_ready;
  logic          halt_req = 1'b0;
  logic          mem_req;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic          halted;
  logic          retired;
  logic [AW-1:0] pc;

  vscpu_ws #(.ADDR_W(AW), .DATA_W(DW), .RESET_PC(0)) dut (
    .clk       (clk),
    .rst       (rst),
    .mem_rdata (mem_rdata),
    .mem_ready (mem_ready),
    .halt_req  (halt_req),
    .mem_req   (mem_req),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .halted    (halted),
    .retired   (retired),
    .pc        (pc)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [AW-1:0] a;
    logic [DW-1:0] d;
  } wexp_t;

  typedef struct {
    logic [AW-1:0] pc;
    int            cyc;
  } rexp_t;

  wexp_t wq[$];
  rexp_t rq[$];

  logic [DW-1:0] mem [0:(1<<AW)-1];
  int ws = 0;
  int wcnt = 0;
  int pcnt = 0;
  int last = 0;
  int n_ret = 0;
  int checks = 0;
  int fails = 0;

  logic          prev_wait = 1'b0;
  logic [AW-1:0] p_addr;
  logic [DW-1:0] p_wdata;
  logic          p_we;

  assign mem_rdata = mem[mem_addr];
  assign mem_ready = (wcnt >= ws);

  always @(posedge clk) begin
    if (rst || !mem_req || mem_ready) wcnt <= 0;
    else wcnt <= wcnt + 1;
    if (!rst && mem_req && mem_we && mem_ready) mem[mem_addr] <= mem_wdata;
  end

  always @(posedge clk) begin
    if (rst) pcnt <= 0;
    else pcnt <= pcnt + 1;
  end

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s got=%0h exp=%0h", nm, got, exp);
    end
  endtask

  // monitor: handshake stability, write and retire scoreboard
  always @(negedge clk) begin
    if (rst) begin
      prev_wait = 1'b0;
      last = 0;
    end else begin
      if (prev_wait) begin
        chk("stable_req", 32'(mem_req), 1);
        chk("stable_addr", 32'(mem_addr), 32'(p_addr));
        chk("stable_wdata", mem_wdata, p_wdata);
        chk("stable_we", 32'(mem_we), 32'(p_we));
      end
      prev_wait = mem_req && !mem_ready;
      p_addr = mem_addr;
      p_wdata = mem_wdata;
      p_we = mem_we;
      if (mem_req && mem_we && mem_ready) begin
        if (wq.size() == 0) begin
          chk("unexpected_write_addr", 32'(mem_addr), 32'hFFFF_FFFF);
        end else begin
          wexp_t w;
          w = wq.pop_front();
          chk("write_addr", 32'(mem_addr), 32'(w.a));
          chk("write_data", mem_wdata, w.d);
        end
      end
      if (retired) begin
        if (rq.size() == 0) begin
          chk("unexpected_retire_pc", 32'(pc), 32'hFFFF_FFFF);
        end else begin
          rexp_t r;
          r = rq.pop_front();
          chk("retire_pc", 32'(pc), 32'(r.pc));
          if (r.cyc >= 0) chk("retire_cycles", pcnt - last, r.cyc);
        end
        chk("retire_not_halted", 32'(halted), 0);
        n_ret = n_ret + 1;
        last = pcnt;
      end
    end
  end

  function automatic logic [31:0] ins(input int op, input int a, input int b);
    return {op[3:0], a[13:0], b[13:0]};
  endfunction

  task automatic poke(input int a, input logic [31:0] d);
    mem[a[AW-1:0]] <= d;
  endtask

  task automatic ew(input int a, input logic [31:0] d);
    wexp_t w;
    w.a = a[AW-1:0];
    w.d = d;
    wq.push_back(w);
  endtask

  task automatic er(input int p, input int c);
    rexp_t r;
    r.pc = p[AW-1:0];
    r.cyc = c;
    rq.push_back(r);
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic reset_core();
    rst = 1'b1;
    halt_req = 1'b0;
    ws = 0;
    wq.delete();
    rq.delete();
    for (int i = 0; i < (1 << AW); i++) mem[i] <= '0;
    repeat (2) tick();
  endtask

  task automatic check_reset_vals();
    chk("rst_mem_req", 32'(mem_req), 0);
    chk("rst_mem_we", 32'(mem_we), 0);
    chk("rst_mem_addr", 32'(mem_addr), 0);
    chk("rst_mem_wdata", mem_wdata, 0);
    chk("rst_pc", 32'(pc), 0);
    chk("rst_retired", 32'(retired), 0);
    chk("rst_halted", 32'(halted), 0);
  endtask

  task automatic wait_ret(input int n, input int maxc);
    int s;
    int i;
    s = n_ret;
    i = 0;
    while ((n_ret - s) < n && i < maxc) begin
      tick();
      i++;
    end
    chk("retire_timeout", 32'((n_ret - s) >= n), 1);
  endtask

  task automatic wait_halt();
    int i;
    i = 0;
    while (!halted && i < 10) begin
      tick();
      i++;
    end
    chk("halted", 32'(halted), 1);
    chk("halt_no_req", 32'(mem_req), 0);
  endtask

  task automatic run(input int n, input int maxc);
    rst = 1'b0;
    tick();
    if (n > 1) wait_ret(n - 1, maxc);
    halt_req = 1'b1;
    wait_ret(1, maxc);
    wait_halt();
  endtask

  task automatic end_test(input string nm);
    chk({nm, "_writes_left"}, 32'(wq.size()), 0);
    chk({nm, "_retires_left"}, 32'(rq.size()), 0);
  endtask

  initial begin
    // reset values, then boot straight into HALT
    reset_core();
    check_reset_vals();
    halt_req = 1'b1;
    rst = 1'b0;
    tick();
    tick();
    chk("boot_halted", 32'(halted), 1);
    chk("boot_no_req", 32'(mem_req), 0);
    chk("boot_pc", 32'(pc), 0);
    halt_req = 1'b0;
    tick();
    chk("boot_fetch_req", 32'(mem_req), 1);
    chk("boot_fetch_addr", 32'(mem_addr), 0);

    // zero-wait ADD, halt mid-instruction, resume at next PC
    reset_core();
    poke(0, ins(0, 100, 101));
    poke(100, 7);
    poke(101, 5);
    poke(1, ins(9, 60, 9));
    ew(100, 12);
    er(1, 5);
    run(1, 50);
    chk("add_pc", 32'(pc), 1);
    chk("add_mem", mem[100], 12);
    halt_req = 1'b0;
    tick();
    chk("resume_req", 32'(mem_req), 1);
    chk("resume_addr", 32'(mem_addr), 1);
    chk("resume_we", 32'(mem_we), 0);
    chk("resume_halted", 32'(halted), 0);
    ew(60, 9);
    er(2, -1);
    halt_req = 1'b1;
    wait_ret(1, 50);
    wait_halt();
    end_test("add");

    // two wait states on every access
    reset_core();
    ws = 2;
    poke(0, ins(9, 50, 14'h3FFF));
    ew(50, 32'h3FFF);
    er(1, 7);
    run(1, 100);
    chk("ws_mem", mem[50], 32'h3FFF);
    end_test("ws");

    // shift boundaries
    reset_core();
    for (int i = 200; i < 206; i++) poke(i, 32'h8000_0001);
    poke(210, 64);
    poke(211, 33);
    poke(0, ins(5, 200, 1));
    poke(1, ins(5, 201, 31));
    poke(2, ins(5, 202, 32));
    poke(3, ins(5, 203, 33));
    poke(4, ins(4, 204, 210));
    poke(5, ins(4, 205, 211));
    ew(200, 32'h4000_0000); er(1, 4);
    ew(201, 32'h0000_0001); er(2, 3);
    ew(202, 32'h8000_0001); er(3, 3);
    ew(203, 32'h0000_0002); er(4, 3);
    ew(204, 32'h0000_0000); er(5, 4);
    ew(205, 32'h0000_0002); er(6, 4);
    run(6, 100);
    end_test("srl");

    // indirect copy and indirect store
    reset_core();
    poke(10, 20);
    poke(20, 32'hABCD);
    poke(0, ins(10, 30, 10));
    poke(1, ins(11, 10, 30));
    ew(30, 32'hABCD); er(1, 5);
    ew(20, 32'hABCD); er(2, 4);
    run(2, 100);
    chk("cpi_mem30", mem[30], 32'hABCD);
    chk("cpii_mem20", mem[20], 32'hABCD);
    end_test("ind");

    // compare, nand, multiply, add-immediate, copy
    reset_core();
    poke(300, 5);
    poke(301, 9);
    poke(302, 32'hF0F0_F0F0);
    poke(303, 32'hFF00_FF00);
    poke(304, 32'h0001_0000);
    poke(305, 32'h0001_0001);
    poke(0, ins(6, 300, 301));
    poke(1, ins(7, 301, 9));
    poke(2, ins(2, 302, 303));
    poke(3, ins(3, 303, 14'h00FF));
    poke(4, ins(14, 304, 305));
    poke(5, ins(15, 305, 3));
    poke(6, ins(1, 300, 14'h3FFF));
    poke(7, ins(8, 306, 302));
    ew(300, 1);              er(1, 5);
    ew(301, 0);              er(2, 3);
    ew(302, 32'h0FFF_0FFF);  er(3, 4);
    ew(303, 32'hFFFF_FFFF);  er(4, 3);
    ew(304, 32'h0001_0000);  er(5, 4);
    ew(305, 32'h0003_0003);  er(6, 3);
    ew(300, 32'h0000_4000);  er(7, 3);
    ew(306, 32'h0FFF_0FFF);  er(8, 3);
    run(8, 200);
    end_test("alu");

    // branches, including PC wrap
    reset_core();
    poke(400, 40);
    poke(401, 0);
    poke(402, 1);
    poke(403, 32'h3FFE);
    poke(0, ins(12, 400, 401));
    poke(40, ins(12, 400, 402));
    poke(41, ins(13, 403, 3));
    poke(1, ins(9, 60, 7));
    er(40, 4);
    er(41, 3);
    er(1, 2);
    ew(60, 7);
    er(2, 2);
    run(4, 100);
    end_test("br");

    // reset while a write is stalled
    reset_core();
    ws = 50;
    poke(0, ins(9, 70, 14'h1234));
    poke(70, 32'h55);
    rst = 1'b0;
    for (int i = 0; i < 120 && !mem_we; i++) tick();
    chk("stall_we", 32'(mem_we), 1);
    chk("stall_addr", 32'(mem_addr), 70);
    chk("stall_wdata", mem_wdata, 32'h1234);
    repeat (3) tick();
    rst = 1'b1;
    tick();
    check_reset_vals();
    chk("abandoned_write", mem[70], 32'h55);
    end_test("rstw");

    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end

endmodule

// File: doc/vscpu_ws.md
# vscpu_ws

Parametrised multi-cycle accumulator-memory CPU executing the 16-opcode VerySimple ISA. It is the next generation of the team's single-port CPU core. Every memory access goes through a req/ready handshake, so the core runs against wait-stated RAM or a bus fabric. Data and address widths are generic, and the core adds a halt/resume control and a retire pulse for debug and verification.

## Interface
- ADDR_W, 14, address width; also width of the A and B instruction fields
- DATA_W, 32, data/instruction width; must satisfy DATA_W >= 2*ADDR_W+4
- RESET_PC, 0, PC value loaded on reset
- clk  in  1  clock, all state on rising edge
- rst  in  1  reset, synchronous, active-high
- mem_rdata  in  DATA_W  read data; valid in the cycle mem_req && mem_ready
- mem_ready  in  1  completes the pending access; may depend combinationally on mem_req
- halt_req  in  1  request to stop at next instruction boundary
- mem_req  out  1  access pending (registered)
- mem_we  out  1  pending access is a write (registered)
- mem_addr  out  ADDR_W  access address (registered)
- mem_wdata  out  DATA_W  write data (registered; 0 on reads)
- halted  out  1  core is in HALT state
- retired  out  1  one-cycle pulse when an instruction completes
- pc  out  ADDR_W  current PC

## Operation
- Instruction fields:
  - op = iw[DATA_W-1 -: 4]
  - A = iw[2*ADDR_W-1:ADDR_W]
  - B = iw[ADDR_W-1:0]
  - bits between op and A are ignored
- Immediates are B, zero-extended. Memory values used as addresses or PC are truncated to their low ADDR_W bits.
- Semantics (M = memory; all arithmetic is modulo 2^DATA_W, unsigned):
  - ADD 0: M[A]=M[A]+M[B]
  - ADDi 1: M[A]=M[A]+B
  - NAND 2: M[A]=~(M[A]&M[B])
  - NANDi 3: M[A]=~(M[A]&B)
  - SRL 4 / SRLi 5, with s = M[B] or B:
    - s<DATA_W: M[A]=M[A]>>s
    - else: M[A]=M[A]<<(s-DATA_W)
    - bits shifted out are lost, so s>=2*DATA_W yields 0
  - LT 6: M[A]=(M[A]<M[B])?1:0
  - LTi 7: M[A]=(M[A]<B)?1:0
  - CP 8: M[A]=M[B]
  - CPi 9: M[A]=B
  - CPI 10: M[A]=M[M[B]]
  - CPIi 11: M[M[A]]=M[B]
  - BZJ 12: PC=(M[B]==0)?M[A]:PC+1
  - BZJi 13: PC=M[A]+B
  - MUL 14: M[A]=low DATA_W bits of M[A]*M[B]
  - MULi 15: M[A]=low bits of M[A]*B
- PC increments by 1 (wrapping at 2^ADDR_W) for every non-branch instruction.
- States: FETCH, RD_A, RD_B, RD_IND, WRITE, HALT. Access sequences:
  - ADD/NAND/SRL/LT/MUL: FETCH, RD_A, RD_B, WRITE
  - immediate ALU ops: FETCH, RD_A, WRITE
  - CP: FETCH, RD_B, WRITE
  - CPi: FETCH, WRITE
  - CPI: FETCH, RD_B, RD_IND(addr M[B]), WRITE(A)
  - CPIi: FETCH, RD_A (pointer latched), RD_B, WRITE(pointer)
  - BZJ: FETCH, RD_B, RD_A, then PC updated; RD_A is always performed
  - BZJi: FETCH, RD_A, then PC updated
- Holding registers: iw, r1 (first operand/pointer), r2. Write data is computed from held operands and latched into mem_wdata.
- Halt:
  - halt_req is sampled only on entry to FETCH, i.e. at the edge an instruction retires, or the first post-reset edge.
  - If halt_req=1, the core goes to HALT instead of issuing a fetch.
  - In HALT: halted=1 and mem_req=0.
  - The first edge with halt_req=0 returns the core to FETCH at the unchanged PC.

## Timing
- Reset values:
  - mem_req, mem_we, retired, halted = 0
  - mem_addr, mem_wdata = 0
  - pc = RESET_PC
  - state = FETCH-pending
- First rising edge with rst=0:
  - mem_req=1, mem_addr=RESET_PC, or HALT if halt_req=1.
- Access completion:
  - An access completes at a rising edge where mem_req && mem_ready.
  - mem_req, mem_we, mem_addr and mem_wdata stay stable until completion.
  - Read data is captured at that edge.
  - The next access's outputs appear in the following cycle, with no idle cycle.
- With mem_ready tied high, cycles per instruction equal the access count:
  - 4: ADD, NAND, SRL, LT, MUL, CPI, CPIi
  - 3: immediate ALU ops, CP, BZJ
  - 2: CPi, BZJi
- Each wait cycle of mem_ready=0 adds exactly one cycle.
- retired=1 for exactly the cycle after the final access completes.
  - At that edge pc also takes its new value.
  - retired is never high in HALT.
- rst asserted mid-instruction:
  - The pending access is abandoned and no write is issued.
  - mem_req=0 in the next cycle and all registers reset.
- Opcode coverage is complete, so no illegal-opcode path exists.

## Test plan
- Zero-wait ADD: M[100]=7, M[101]=5, instruction at 0 = ADD 100,101 -> M[100]=12, pc=1, retired pulse 4 cycles after first fetch.
- Wait states: mem_ready low 2 cycles on every access, CPi 50,0x3FFF -> M[50]=0x3FFF, instruction takes 6 cycles, mem_addr/mem_wdata stable while mem_ready=0.
- SRL boundaries: M[A]=0x80000001 with s=1, 31, 32, 33, 64:
  - s=1 -> 0x40000000
  - s=31 -> 1
  - s=32 -> 0x80000001
  - s=33 -> 2
  - s=64 -> 0
- Indirect: M[10]=20, M[20]=0xABCD, CPI 30,10 -> M[30]=0xABCD; then CPIi 10,30 -> M[20]=0xABCD.
- Branches:
  - BZJ with M[B]=0 and M[A]=40 -> pc=40
  - same with M[B]=1 -> pc=old+1
  - BZJi with M[A]=0x3FFE, B=3 -> pc=1 (wrap)
- Halt/reset:
  - halt_req raised mid-ADD -> ADD completes, then halted=1, mem_req=0.
  - Release halt -> fetch at next PC.
  - rst mid-WRITE wait -> no write occurs, pc=RESET_PC.
